cgra_config_loader: RTL

- Synthesizable successor to the file-driven instruction streamer.
- Accepts instruction phits from the m00_axi read-data channel using a valid/ready/last handshake.
- Unpacks each phit into NUM_COL per-column instruction words and writes them into the per-column CGRA config memories at a programmable base address and length.
- Adds column masking, broadcast mode, rlast/length checking, and done/error reporting.

---
 rtl/cgra_config_loader_pkg.sv | 22 ++
 rtl/cgra_config_loader_phit_unpack.sv | 28 ++
 rtl/cgra_config_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cgra_config_loader_pkg.sv
// Shared constants and enums for the CGRA config loader and its lane unpacker.
package cgra_config_loader_pkg;

   localparam int CFG_PHIT_SIZE    = 512;
   localparam int CFG_DWIDTH_INT   = 32;
   localparam int CFG_NUM_COL      = 16;
   localparam int CFG_DEPTH_CONFIG = 64;

   typedef enum logic [1:0] {
      CFG_OK         = 2'd0,
      CFG_BAD_PARAM  = 2'd1,
      CFG_EARLY_LAST = 2'd2,
      CFG_NO_LAST    = 2'd3
   } cfg_err_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FIN  = 2'd2
   } cfg_ld_state_t;

endpackage

// File: rtl/cgra_config_loader_phit_unpack.sv
// Splits one read-data phit into per-column instruction words, optionally replicating lane 0.
module cfg_phit_unpack
   import cgra_config_loader_pkg::*;
#(
   parameter int PHIT_SIZE  = CFG_PHIT_SIZE,
   parameter int DWIDTH_INT = CFG_DWIDTH_INT,
   parameter int NUM_COL    = CFG_NUM_COL
) (
   input  logic [PHIT_SIZE-1:0]                 rdata_i,
   input  logic                                 broadcast_i,
   output logic [NUM_COL-1:0][DWIDTH_INT-1:0]   lanes_o
);

   always_comb begin
      lanes_o = '0;
      for (int unsigned c = 0; c < NUM_COL; c++) begin
         lanes_o[c] = broadcast_i ? rdata_i[DWIDTH_INT-1:0]
                                  : rdata_i[c*DWIDTH_INT +: DWIDTH_INT];
      end
   end

   // Phit bits beyond the last column carry nothing for the array.
   if (PHIT_SIZE > NUM_COL*DWIDTH_INT) begin : g_spare
      logic unused_spare;
      assign unused_spare = ^rdata_i[PHIT_SIZE-1:NUM_COL*DWIDTH_INT];
   end

endmodule

// File: rtl/cgra_config_loader.sv
// Streams instruction phits from the AXI read channel into the per-column config memories.
module cgra_config_loader
   import cgra_config_loader_pkg::*;
#(
   parameter int PHIT_SIZE    = CFG_PHIT_SIZE,
   parameter int DWIDTH_INT   = CFG_DWIDTH_INT,
   parameter int NUM_COL      = CFG_NUM_COL,
   parameter int DEPTH_CONFIG = CFG_DEPTH_CONFIG,
   parameter int ADDR_W       = $clog2(DEPTH_CONFIG)
) (
   input  logic                           ap_clk,
   input  logic                           ap_rst_n,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              base_addr,
   input  logic [ADDR_W:0]                num_words,
   input  logic [NUM_COL-1:0]             col_mask,
   input  logic                           broadcast,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [1:0]                     err_code,
   input  logic [PHIT_SIZE-1:0]           m00_axi_rdata,
   input  logic                           m00_axi_rvalid,
   output logic                           m00_axi_rready,
   input  logic                           m00_axi_rlast,
   output logic [NUM_COL-1:0]             cfg_we,
   output logic [ADDR_W-1:0]              cfg_addr,
   output logic [NUM_COL*DWIDTH_INT-1:0]  cfg_wdata
);

   cfg_ld_state_t                        state_q, state_d;
   logic [ADDR_W-1:0]                    base_q, base_d;
   logic [ADDR_W:0]                      num_q, num_d;
   logic [ADDR_W:0]                      count_q, count_d;
   logic [NUM_COL-1:0]                   mask_q, mask_d;
   logic                                 bcast_q, bcast_d;
   logic                                 err_q, err_d;
   cfg_err_t                             code_q, code_d;
   logic [NUM_COL-1:0]                   we_q, we_d;
   logic [ADDR_W-1:0]                    addr_q, addr_d;
   logic [NUM_COL-1:0][DWIDTH_INT-1:0]   wdata_q, wdata_d;

   logic [NUM_COL-1:0][DWIDTH_INT-1:0]   lanes;
   logic [ADDR_W+1:0]                    end_addr;
   logic                                 bad_param;
   logic                                 accept;
   logic                                 last_beat;

   cfg_phit_unpack #(
      .PHIT_SIZE  (PHIT_SIZE),
      .DWIDTH_INT (DWIDTH_INT),
      .NUM_COL    (NUM_COL)
   ) u_unpack (
      .rdata_i     (m00_axi_rdata),
      .broadcast_i (bcast_q),
      .lanes_o     (lanes)
   );

   // One extra bit over the address math so base+num_words cannot wrap in the check.
   assign end_addr  = {2'b00, base_addr} + {1'b0, num_words};
   assign bad_param = (num_words == '0) || (end_addr > (ADDR_W+2)'(DEPTH_CONFIG));
   assign accept    = (state_q == LOAD) && m00_axi_rvalid;
   assign last_beat = (count_q == num_q - (ADDR_W+1)'(1));

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      num_d   = num_q;
      count_d = count_q;
      mask_d  = mask_q;
      bcast_d = bcast_q;
      err_d   = err_q;
      code_d  = code_q;
      we_d    = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = base_addr;
               num_d   = num_words;
               mask_d  = col_mask;
               bcast_d = broadcast;
               count_d = '0;
               err_d   = 1'b0;
               code_d  = CFG_OK;
               if (bad_param) begin
                  err_d   = 1'b1;
                  code_d  = CFG_BAD_PARAM;
                  state_d = FIN;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               we_d    = mask_q;
               addr_d  = ADDR_W'({1'b0, base_q} + count_q);
               wdata_d = lanes;
               count_d = count_q + (ADDR_W+1)'(1);
               if (last_beat) begin
                  state_d = FIN;
                  if (!m00_axi_rlast) begin
                     err_d  = 1'b1;
                     code_d = CFG_NO_LAST;
                  end
               end else if (m00_axi_rlast) begin
                  err_d   = 1'b1;
                  code_d  = CFG_EARLY_LAST;
                  state_d = FIN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         num_q   <= '0;
         count_q <= '0;
         mask_q  <= '0;
         bcast_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= CFG_OK;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         num_q   <= num_d;
         count_q <= count_d;
         mask_q  <= mask_d;
         bcast_q <= bcast_d;
         err_q   <= err_d;
         code_q  <= code_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign done           = (state_q == FIN);
   assign m00_axi_rready = (state_q == LOAD);
   assign err            = err_q;
   assign err_code       = code_q;
   assign cfg_we         = we_q;
   assign cfg_addr       = addr_q;
   assign cfg_wdata      = wdata_q;

endmodule
